// File: rtl/calc_pkg.sv
// Shared types and constants for the result display path: converter FSM
// states, BCD width and the active-low seven-segment code table.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int BCD_W = 12;

  // Segment codes, bit order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Decimal digit to segment code; non-decimal nibbles show blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble),
// one bit per cycle, MSB first. Starts are ignored while busy.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_t      state;
  conv_state_t      state_next;
  logic [7:0]       bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [2:0]       bit_cnt;
  logic [BCD_W-1:0] bcd_adj;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    add3 = (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  assign bcd_adj = {add3(bcd_sr[11:8]), add3(bcd_sr[7:4]), add3(bcd_sr[3:0])};
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign bcd     = bcd_sr;

  // Next-state: eight shifts, one DONE cycle, then back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus shift datapath; reset aborts any conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          bin_sr  <= bin;
          bcd_sr  <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          bcd_sr  <= {bcd_adj[BCD_W-2:0], bin_sr[7]};
          bin_sr  <= {bin_sr[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/result_display_driver.sv
// Drives a 4-digit multiplexed seven-segment display (sign, hundreds,
// tens, ones) from an 8-bit magnitude plus sign flag.
module result_display_driver
  import calc_pkg::*;
#(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       neg,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             neg_pend;
  logic [BCD_W-1:0] disp_bcd;
  logic             disp_neg;
  logic [15:0]      refresh_cnt;
  logic [1:0]       digit_idx;
  logic [6:0]       seg_next;
  logic [3:0]       an_next;
  logic [3:0]       ones, tens, hund;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (value),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign ones = disp_bcd[3:0];
  assign tens = disp_bcd[7:4];
  assign hund = disp_bcd[11:8];

  // Sign is taken with the accepted load; the display only changes on done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_pend <= 1'b0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
    end else begin
      if (load && !busy) neg_pend <= neg;
      if (conv_done) begin
        disp_bcd <= conv_bcd;
        disp_neg <= neg_pend;
      end
    end
  end

  // Free-running refresh timer stepping the digit index on each wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_DIV - 16'd1) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  // Select digit code with leading-zero and sign blanking.
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = 4'b1111;
    case (digit_idx)
      2'd0: begin
        an_next  = 4'b1110;
        seg_next = seg_encode(ones);
      end
      2'd1: begin
        an_next  = 4'b1101;
        seg_next = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_encode(tens);
      end
      2'd2: begin
        an_next  = 4'b1011;
        seg_next = (hund == 4'd0) ? SEG_BLANK : seg_encode(hund);
      end
      default: begin
        an_next  = 4'b0111;
        seg_next = (disp_neg && disp_bcd != '0) ? SEG_MINUS : SEG_BLANK;
      end
    endcase
  end

  // seg and an share one register stage so they switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_0;
      an  <= 4'b1110;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_result_display_driver.sv
// Directed self-checking bench for result_display_driver (REFRESH_DIV=4).
module tb_result_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] value;
  logic       neg;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_MINUS = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_SIGN = 4'b0111;

  result_display_driver #(.REFRESH_DIV(16'd4)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .neg   (neg),
    .busy  (busy),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic do_load(input logic [7:0] v, input logic n);
    load  = 1'b1;
    value = v;
    neg   = n;
    tick();
    load  = 1'b0;
  endtask

  // busy must read 1 for k more sampled cycles, then 0.
  task automatic expect_busy(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      chk(tag, 16'(busy), 16'd1);
      tick();
    end
    chk(tag, 16'(busy), 16'd0);
  endtask

  // Wait for a fresh entry into the given digit slot, then check seg.
  task automatic check_digit(input logic [3:0] target, input logic [6:0] exp, input string tag);
    int n = 0;
    while (an === target && n < 40) begin tick(); n++; end
    while (an !== target && n < 40) begin tick(); n++; end
    if (n >= 40) timeout(tag);
    else chk(tag, 16'(seg), 16'(exp));
  endtask

  logic [3:0] exp_seq [5];
  logic [3:0] cur;
  int         len;
  int         n;

  initial begin
    exp_seq[0] = AN_TENS; exp_seq[1] = AN_HUND; exp_seq[2] = AN_SIGN;
    exp_seq[3] = AN_ONES; exp_seq[4] = AN_TENS;
    rst = 1'b1; load = 1'b0; value = '0; neg = 1'b0;
    tick(); tick();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_an",   16'(an),   16'(AN_ONES));
    chk("rst_seg",  16'(seg),  16'(S0));
    rst = 1'b0;

    // Refresh: each slot held exactly 4 cycles, fixed order.
    n = 0;
    while (an === AN_ONES && n < 40) begin tick(); n++; end
    if (n >= 40) timeout("refresh_start");
    for (int i = 0; i < 5; i++) begin
      cur = an;
      len = 0;
      while (an === cur && len < 40) begin tick(); len++; end
      chk("refresh_an",   16'(cur), 16'(exp_seq[i]));
      chk("refresh_hold", 16'(len), 16'd4);
    end

    // 255, positive.
    do_load(8'd255, 1'b0);
    expect_busy(9, "busy_255");
    check_digit(AN_ONES, S5, "d255_ones");
    check_digit(AN_TENS, S5, "d255_tens");
    check_digit(AN_HUND, S2, "d255_hund");
    check_digit(AN_SIGN, S_BLANK, "d255_sign");

    // 7, negative: leading zeros blank, minus shown.
    do_load(8'd7, 1'b1);
    expect_busy(9, "busy_7");
    check_digit(AN_ONES, S7, "d7_ones");
    check_digit(AN_TENS, S_BLANK, "d7_tens");
    check_digit(AN_HUND, S_BLANK, "d7_hund");
    check_digit(AN_SIGN, S_MINUS, "d7_sign");

    // 0 with neg: no minus on zero magnitude.
    do_load(8'd0, 1'b1);
    expect_busy(9, "busy_0");
    check_digit(AN_ONES, S0, "d0_ones");
    check_digit(AN_TENS, S_BLANK, "d0_tens");
    check_digit(AN_SIGN, S_BLANK, "d0_sign");

    // 100, then 42/neg at N+3 must be ignored; old value held meanwhile.
    do_load(8'd100, 1'b0);
    chk("hold_old_seg", 16'(busy), 16'd1);
    tick();
    chk("ign_busy", 16'(busy), 16'd1);
    tick();
    do_load(8'd42, 1'b1);
    expect_busy(6, "busy_100");
    check_digit(AN_ONES, S0, "d100_ones");
    check_digit(AN_TENS, S0, "d100_tens");
    check_digit(AN_HUND, S1, "d100_hund");
    check_digit(AN_SIGN, S_BLANK, "d100_sign");

    // Old result stays visible during a conversion.
    check_digit(AN_HUND, S1, "pre_hund");
    do_load(8'd200, 1'b1);
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_an",   16'(an),   16'(AN_ONES));
    chk("arst_seg",  16'(seg),  16'(S0));
    #1 rst = 1'b0;
    chk("post_rst_seg", 16'(seg), 16'(S0));
    // Load accepted on the first edge after reset release.
    do_load(8'd42, 1'b1);
    chk("post_rst_an",  16'(an),  16'(AN_ONES));
    chk("post_rst_seg2", 16'(seg), 16'(S0));
    expect_busy(9, "busy_42");
    check_digit(AN_ONES, S2, "d42_ones");
    check_digit(AN_TENS, S4, "d42_tens");
    check_digit(AN_HUND, S_BLANK, "d42_hund");
    check_digit(AN_SIGN, S_MINUS, "d42_sign");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_display_driver.md
RESULT_DISPLAY_DRIVER -- requirements
Module: result_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 16'd50000, meaning clock cycles each digit stays enabled; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port load, input, 1, single-cycle strobe capturing value/neg.
REQ-005 SHALL have port value, input, 8, unsigned magnitude from the adder/subtractor result bus.
REQ-006 SHALL have port neg, input, 1, sign flag; 1 = show minus.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port seg, output, 7, segment drive {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port an, output, 4, digit enable, active-low, one-hot-low.

Function
REQ-010 SHALL use FSM states IDLE, SHIFT, DONE: IDLE->SHIFT on load; SHIFT->DONE after 8th shift; DONE->IDLE unconditionally.
REQ-011 SHALL convert binary to 3 BCD digits by shift-add-3 (double-dabble), one bit per cycle, MSB first.
REQ-012 SHALL in SHIFT, before each shift, add 3 to any BCD nibble >= 5.
REQ-013 SHALL capture value/neg on the load cycle N, assert busy cycles N+1..N+9, and update displayed digits/sign at the edge ending N+9.
REQ-014 SHALL ignore load while busy=1; the conversion in progress and its captured operands are unaffected.
REQ-015 SHALL hold the displayed digits/sign unchanged during conversion (old result visible until DONE).
REQ-016 SHALL refresh with a counter counting 0..REFRESH_DIV-1 then wrapping to 0; on wrap, digit index advances 0->1->2->3->0.
REQ-017 SHALL map digit index 0 = ones (an=1110), 1 = tens (1101), 2 = hundreds (1011), 3 = sign (0111).
REQ-018 SHALL blank hundreds when zero, and blank tens when hundreds and tens are zero; ones never blanked.
REQ-019 SHALL drive sign digit as minus (7'b0111111) when latched neg=1 and magnitude non-zero, else blank (7'b1111111).
REQ-020 SHALL encode digits 0-9 with the standard active-low table (0 = 7'b1000000, 1 = 7'b1111001, ..., 9 = 7'b0010000).
REQ-021 SHALL keep seg/an registered so that both change on the same clock edge (no glitch between digits).
REQ-022 SHALL keep refresh running independently of the FSM, including while busy.

Reset
REQ-023 SHALL on rst=1 immediately force: FSM IDLE, busy=0, BCD digits 0, latched neg 0, refresh counter 0, digit index 0, an=4'b1110, seg=7'b1000000.
REQ-024 SHALL abort any conversion on mid-operation reset; no partial result ever reaches the display.
REQ-025 SHALL accept load on the first rising edge after rst deasserts.

Structure
REQ-026 SHALL place FSM state enum, the segment table constants (SEG_BLANK, SEG_MINUS, digit codes) and BCD width in shared package calc_pkg.
REQ-027 SHALL implement the conversion (REQ-010..REQ-015) as sub-module bin2bcd_seq (ports clk, rst, start, bin[7:0], busy, done, bcd[11:0]); refresh/segment logic stays in the top.

Verification
REQ-028 SHALL cover: load value=255, neg=0 at cycle N -> busy high N+1..N+9; digits 2/5/5; sign blank.
REQ-029 SHALL cover: load value=7, neg=1 -> ones=7'b1111000, tens and hundreds blank, sign=7'b0111111.
REQ-030 SHALL cover: load value=0, neg=1 -> ones shows 0, sign blank.
REQ-031 SHALL cover: load 100 then load 42 at N+3 -> second ignored; final display 1/0/0 (tens 0 shown).
REQ-032 SHALL cover: REFRESH_DIV=4 -> an sequence 1110,1101,1011,0111,1110, each held exactly 4 cycles.
REQ-033 SHALL cover: rst pulse at N+4 during load of 200 -> outputs at reset values asynchronously; display shows 0; busy=0.
